servo_pulse_rx: RTL and testbench

SERVO_PULSE_RX -- requirements
Module: servo_pulse_rx

---
 rtl/motor_pkg.sv | 35 +++
 rtl/servo_pulse_rx_sync2.sv | 23 ++
 rtl/servo_pulse_rx.sv | 172 +++++++++++++++++
 tb/tb_servo_pulse_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared motor definitions: instruction codes, driver pulse widths and frame
// length used by both motor_driver and servo_pulse_rx, plus the receiver FSM
// state type.
package motor_pkg;

    // Two-bit drive instruction codes
    localparam logic [1:0] INSTR_BACK = 2'b10;
    localparam logic [1:0] INSTR_STOP = 2'b11;
    localparam logic [1:0] INSTR_FWD  = 2'b01;

    // High widths (in PWM ticks) that motor_driver emits for each instruction
    localparam int DRV_W_BACK = 154;
    localparam int DRV_W_STOP = 230;
    localparam int DRV_W_FWD  = 307;

    // PWM frame length in ticks
    localparam int FRAME_LEN = 3072;

    // Pulse receiver states
    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE
    } rx_state_t;

    // Pulse width the driver produces for a given instruction code
    function automatic int drive_width(input logic [1:0] code);
        case (code)
            INSTR_BACK: return DRV_W_BACK;
            INSTR_FWD:  return DRV_W_FWD;
            default:    return DRV_W_STOP;
        endcase
    endfunction

endpackage

// File: rtl/servo_pulse_rx_sync2.sv
// Two-flop synchronizer bringing the asynchronous servo pulse into the clk
// domain. Both flops clear to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage shift register to resolve metastability on d
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/servo_pulse_rx.sv
// Servo pulse receiver: measures the high width of each pwm_in pulse in clk
// cycles and decodes it into a back/stop/forward instruction.
// Optional failsafe timeout is enabled by defining PWM_RX_TIMEOUT_EN.
module servo_pulse_rx
    import motor_pkg::*;
#(
    parameter int T_MIN     = 120,
    parameter int T_STOP_LO = 192,
    parameter int T_FWD_LO  = 268,
    parameter int T_MAX     = 346,
    parameter int T_TIMEOUT = 6144
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [1:0] instr,
    output logic       valid,
    output logic       err,
    output logic       timeout
);

    localparam logic [11:0] LIM_MIN  = 12'(T_MIN);
    localparam logic [11:0] LIM_STOP = 12'(T_STOP_LO);
    localparam logic [11:0] LIM_FWD  = 12'(T_FWD_LO);
    localparam logic [11:0] LIM_MAX  = 12'(T_MAX);

    logic        pin;
    logic        pin_d;
    logic        rise;
    logic        fall;
    logic [1:0]  primed;
    rx_state_t   state;
    rx_state_t   state_next;
    logic [11:0] width;
    logic [11:0] width_next;
    logic [11:0] width_inc;
    logic        valid_next;
    logic        err_next;
    logic [1:0]  instr_new;
    logic        to_hit;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pwm_in),
        .q     (pin)
    );

    assign rise      = pin & ~pin_d;
    assign fall      = ~pin & pin_d;
    assign width_inc = (width == 12'hFFF) ? width : width + 12'd1;

    // Previous-cycle pin for edge detection, and a fill marker so WAIT_LOW
    // ignores the reset-forced 0 in the synchronizer before it reflects pwm_in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pin_d  <= 1'b0;
            primed <= 2'b00;
        end else begin
            pin_d  <= pin;
            primed <= {primed[0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_LOW;
        end else begin
            state <= state_next;
        end
    end

    // Next state, width counting and pulse classification
    always_comb begin
        state_next = state;
        width_next = width;
        valid_next = 1'b0;
        err_next   = 1'b0;
        instr_new  = instr;
        case (state)
            WAIT_LOW: begin
                if (primed[1] && !pin) begin
                    state_next = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    width_next = 12'd1;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (pin) begin
                    width_next = width_inc;
                    if (width_inc > LIM_MAX) begin
                        err_next   = 1'b1;
                        state_next = WAIT_LOW;
                    end
                end else if (fall) begin
                    state_next = WAIT_RISE;
                    if (width < LIM_MIN) begin
                        err_next = 1'b1;
                    end else begin
                        valid_next = 1'b1;
                        if (width < LIM_STOP) begin
                            instr_new = INSTR_BACK;
                        end else if (width < LIM_FWD) begin
                            instr_new = INSTR_STOP;
                        end else begin
                            instr_new = INSTR_FWD;
                        end
                    end
                end
            end
            default: state_next = WAIT_LOW;
        endcase
    end

    // Width counter, strobes and instruction register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            width <= 12'd0;
            valid <= 1'b0;
            err   <= 1'b0;
            instr <= INSTR_STOP;
        end else begin
            width <= width_next;
            valid <= valid_next;
            err   <= err_next;
            if (valid_next) begin
                instr <= instr_new;
            end else if (to_hit) begin
                instr <= INSTR_STOP;
            end
        end
    end

`ifdef PWM_RX_TIMEOUT_EN
    localparam logic [12:0] TO_LIM = 13'(T_TIMEOUT);

    logic [12:0] to_cnt;
    logic        to_q;

    assign to_hit  = !valid_next && (to_cnt == TO_LIM - 13'd1);
    assign timeout = to_q;

    // Failsafe counter: cleared by each valid strobe, holds once at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= 13'd0;
            to_q   <= 1'b0;
        end else if (valid_next) begin
            to_cnt <= 13'd0;
            to_q   <= 1'b0;
        end else if (to_cnt != TO_LIM) begin
            to_cnt <= to_cnt + 13'd1;
            if (to_hit) begin
                to_q <= 1'b1;
            end
        end
    end
`else
    // Without the failsafe, timeout is constant 0; the expression only keeps
    // the T_TIMEOUT parameter referenced in this build
    localparam logic TIMEOUT_TIE = 1'b0 & (T_TIMEOUT > 0);

    assign to_hit  = 1'b0;
    assign timeout = TIMEOUT_TIE;
`endif

endmodule

// File: tb/tb_servo_pulse_rx.sv
// Self-checking bench for servo_pulse_rx: directed and random pulses compared
// against a width-classification model with expected event timing.
`timescale 1ns/1ps
module tb_servo_pulse_rx;
    import motor_pkg::*;

    localparam int T_MIN     = 120;
    localparam int T_STOP_LO = 192;
    localparam int T_FWD_LO  = 268;
    localparam int T_MAX     = 346;
    localparam int T_TIMEOUT = 6144;

    typedef struct {
        int         cyc;
        logic       v;
        logic       e;
        logic [1:0] instr;
        logic       to;
    } ev_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       pwm_in = 1'b0;
    logic [1:0] instr;
    logic       valid;
    logic       err;
    logic       timeout;

    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    int         last_ev_cyc = 0;
    logic [1:0] model_instr = 2'b11;
    ev_t        ev_q[$];

    servo_pulse_rx #(
        .T_MIN     (T_MIN),
        .T_STOP_LO (T_STOP_LO),
        .T_FWD_LO  (T_FWD_LO),
        .T_MAX     (T_MAX),
        .T_TIMEOUT (T_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pwm_in  (pwm_in),
        .instr   (instr),
        .valid   (valid),
        .err     (err),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp stimulus and observed strobes
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid/err strobe with its cycle and the outputs around it
    always @(negedge clk) begin
        if (reset && (valid || err)) begin
            ev_q.push_back(ev_t'{cyc, valid, err, instr, timeout});
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one high pulse then a low gap, and compare the single resulting
    // strobe against the width rules
    task automatic applyStimulus(input int high, input int low, input string tag);
        int         t0;
        int         tf;
        int         exp_cyc;
        logic       exp_err;
        ev_t        ev;
        t0 = cyc;
        pwm_in = 1'b1;
        tick(high);
        pwm_in = 1'b0;
        tf = cyc;
        tick(low);
        if (high > T_MAX) begin
            exp_err = 1'b1;
            exp_cyc = t0 + T_MAX + 3;
        end else if (high < T_MIN) begin
            exp_err = 1'b1;
            exp_cyc = tf + 3;
        end else begin
            exp_err = 1'b0;
            exp_cyc = tf + 3;
            if (high < T_STOP_LO)     model_instr = 2'b10;
            else if (high < T_FWD_LO) model_instr = 2'b11;
            else                      model_instr = 2'b01;
        end
        last_ev_cyc = exp_cyc;
        checkOutput({tag, "_nev"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            ev = ev_q.pop_front();
            checkOutput({tag, "_err"}, ev.e, exp_err);
            checkOutput({tag, "_valid"}, ev.v, !exp_err);
            checkOutput({tag, "_cyc"}, ev.cyc, exp_cyc);
            checkOutput({tag, "_instr"}, ev.instr, model_instr);
            if (!exp_err) checkOutput({tag, "_to"}, ev.to, 0);
        end
        ev_q.delete();
    endtask

    initial begin
        int         bnd[8];
        logic [1:0] codes[3];
        bnd   = '{119, 120, 191, 192, 267, 268, 346, 347};
        codes = '{INSTR_BACK, INSTR_STOP, INSTR_FWD};

        // Reset state
        tick(3);
        checkOutput("rst_instr", instr, 2'b11);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_to", timeout, 0);
        reset = 1'b1;
        tick(10);

        // Back pulses in full frames
        for (int i = 0; i < 3; i++) applyStimulus(DRV_W_BACK, FRAME_LEN - DRV_W_BACK, "frame");

        // Classification boundaries
        for (int i = 0; i < 8; i++) applyStimulus(bnd[i], 100, $sformatf("bnd%0d", bnd[i]));

        // Random widths around the decision thresholds
        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom_range(100, 360), $urandom_range(8, 120), "rnd");
        end

        // Reset released while pwm_in is already high
        reset = 1'b0;
        pwm_in = 1'b1;
        model_instr = 2'b11;
        ev_q.delete();
        tick(3);
        reset = 1'b1;
        tick(200);
        pwm_in = 1'b0;
        tick(30);
        checkOutput("rsthi_nev", ev_q.size(), 0);
        checkOutput("rsthi_instr", instr, 2'b11);
        applyStimulus(DRV_W_FWD, 50, "rsthi_next");

        // Reset asserted in the middle of a stop pulse
        applyStimulus(DRV_W_BACK, 50, "pre_rst");
        pwm_in = 1'b1;
        tick(100);
        reset = 1'b0;
        #1;
        checkOutput("rstmid_instr", instr, 2'b11);
        checkOutput("rstmid_valid", valid, 0);
        checkOutput("rstmid_err", err, 0);
        model_instr = 2'b11;
        ev_q.delete();
        tick(5);
        reset = 1'b1;
        tick(DRV_W_STOP - 105);
        pwm_in = 1'b0;
        tick(50);
        checkOutput("rstmid_nev", ev_q.size(), 0);
        applyStimulus(DRV_W_FWD, 50, "post_rst");

        // Loopback of driver-style frames stepping through the instructions
        for (int c = 0; c < 3; c++) begin
            applyStimulus(drive_width(codes[c]), FRAME_LEN - drive_width(codes[c]), "loop");
            checkOutput("loop_match", instr, codes[c]);
            applyStimulus(drive_width(codes[c]), FRAME_LEN - drive_width(codes[c]), "loop2");
        end

`ifdef PWM_RX_TIMEOUT_EN
        // Failsafe after a long silence, recovery on the next pulse
        applyStimulus(DRV_W_FWD, 8, "pre_to");
        while (cyc < last_ev_cyc + T_TIMEOUT - 1) tick(1);
        @(negedge clk);
        checkOutput("to_early", timeout, 0);
        checkOutput("to_early_instr", instr, 2'b01);
        @(negedge clk);
        checkOutput("to_set", timeout, 1);
        checkOutput("to_instr", instr, 2'b11);
        model_instr = 2'b11;
        @(posedge clk);
        #1;
        applyStimulus(DRV_W_BACK, 50, "post_to");
        checkOutput("to_clear", timeout, 0);
`else
        checkOutput("to_tied", timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
